lsu_stream: RTL
===============

LSU_STREAM -- requirements
Module: lsu_stream

Interface
Parameters:
REQ-001 DW, 32, data width of PE and memory data.
REQ-002 NPE, 4, number of PE input channels; pe_sel width is clog2(NPE).
REQ-003 AW, 10, memory address width.
REQ-004 DEPTH, 4, store FIFO depth and maximum outstanding loads; power of two, 2..16.
Ports:
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle command pulse, sampled only in IDLE.
REQ-008 cfg_mode  in  1  0=LOAD, 1=STORE.
REQ-009 cfg_pe_sel  in  clog2(NPE)  store source channel.
REQ-010 cfg_base, cfg_stride  in  AW each  address generator base and stride.
REQ-011 cfg_count  in  16  number of transfers.
REQ-012 pe_data  in  NPE*DW  PE outputs; channel k at bits [k*DW +: DW].
REQ-013 pe_valid  in  1; pe_ready  out  1  store-data handshake.
REQ-014 req_valid  out  1; req_ready  in  1; req_we  out  1; req_addr  out  AW; req_wdata  out  DW  memory request channel.
REQ-015 rsp_valid  in  1; rsp_data  in  DW  in-order load responses.
REQ-016 pe_out  out  DW; pe_out_valid  out  1  load data to PE array.
REQ-017 busy  out  1; done  out  1  status.

Function
REQ-018 FSM states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-019 IDLE: on start, latch all cfg_* fields and go to RUN; if cfg_count = 0, go to DONE instead.
REQ-020 start outside IDLE is ignored; latched cfg does not change.
REQ-021 Address generator: address of transfer i = cfg_base + i*cfg_stride, modulo 2^AW (wraps, no error); incremented only on req_valid && req_ready.
REQ-022 A request is accepted on req_valid && req_ready; req_valid, req_we, req_addr and req_wdata hold stable until acceptance.
REQ-023 STORE: pe_ready = RUN && store FIFO not full && pushes < count; push of pe_data channel cfg_pe_sel on pe_valid && pe_ready.
REQ-024 STORE: req_valid = FIFO not empty; req_we = 1; req_wdata = FIFO head; pop on acceptance.
REQ-025 FIFO simultaneous push and pop: occupancy unchanged; a push to a full FIFO is never taken, even when a pop occurs in the same cycle.
REQ-026 STORE completes when count writes have been accepted.
REQ-027 LOAD: req_valid = RUN && issued < count && outstanding < DEPTH; req_we = 0.
REQ-028 outstanding +1 on accepted load, -1 on rsp_valid, unchanged when both occur in the same cycle.
REQ-029 rsp_valid is ignored when outstanding = 0.
REQ-030 On rsp_valid, pe_out <= rsp_data and pe_out_valid = 1 for one cycle (1-cycle latency); pe_out holds its value otherwise.
REQ-031 LOAD completes when count responses have been received.
REQ-032 On completion go to DONE; DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-033 Counters are 16 bits; count 65535 completes without overflow.

Reset
REQ-034 On rst: state IDLE; FIFO, issued, outstanding and address counters cleared; req_valid, pe_ready, pe_out_valid, done, busy = 0; pe_out = 0.
REQ-035 rst mid-operation aborts the transfer and discards queued store data and outstanding responses, without a done pulse.

Configuration
REQ-036 Macro LSU_STALL_CNT_EN: when defined, adds output stall_cnt (32 bits), which increments each cycle that req_valid && !req_ready, is cleared on rst and on accepted start, and saturates at 2^32-1.
REQ-037 When LSU_STALL_CNT_EN is not defined, the port and its logic are absent; all other behaviour is identical.

Verification
REQ-038 STORE, base=0x10, stride=4, count=3, pe_sel=2, req_ready=1, channel 2 data A,B,C -> writes A@0x10, B@0x14, C@0x18; done one cycle after the last acceptance.
REQ-039 LOAD, base=0x3FE, stride=1, count=4, AW=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; each rsp_data appears on pe_out one cycle later.
REQ-040 LOAD, count=8, DEPTH=4, responses delayed 10 cycles -> exactly 4 requests issued, then req_valid low until the first response arrives.
REQ-041 STORE with req_ready=0 for 20 cycles and pe_valid=1 -> pe_ready drops after 4 pushes; stall_cnt=20 when LSU_STALL_CNT_EN is defined.
REQ-042 start with cfg_count=0 -> no requests issued; done high in the second cycle after start.
REQ-043 rst asserted after 2 of 5 stores -> all outputs return to reset values next cycle; new start works normally with no stale data.

Source files
------------

// File: rtl/lsu_stream.sv
// ---------------------------------------------------------------------------
// lsu_stream -- streaming load/store unit between a PE array and a memory port
//
// A command latched in IDLE starts a strided transfer of cfg_count words.
//   STORE: words come from one PE channel (cfg_pe_sel), are buffered in a
//          DEPTH-entry FIFO and written to cfg_base + i*cfg_stride.
//   LOAD : read requests are issued to cfg_base + i*cfg_stride, with at most
//          DEPTH reads in flight; in-order responses are forwarded to pe_out
//          one cycle after they arrive.
// The transfer ends in DONE, where done pulses for one cycle before IDLE.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start, cfg_*                  command pulse and its configuration
//   pe_data/pe_valid/pe_ready     store-data input from the PE array
//   req_*                         memory request channel (valid/ready)
//   rsp_valid/rsp_data            in-order load responses
//   pe_out/pe_out_valid           load data to the PE array
//   busy, done                    status
//   stall_cnt                     cycles with req_valid && !req_ready
//                                 (only when LSU_STALL_CNT_EN is defined)
//
// Build option
//   LSU_STALL_CNT_EN : adds the stall_cnt output and its counter.
// ---------------------------------------------------------------------------
module lsu_stream #(
    parameter int DW    = 32,
    parameter int NPE   = 4,
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_mode,
    input  logic [$clog2(NPE)-1:0] cfg_pe_sel,
    input  logic [AW-1:0]          cfg_base,
    input  logic [AW-1:0]          cfg_stride,
    input  logic [15:0]            cfg_count,
    input  logic [NPE*DW-1:0]      pe_data,
    input  logic                   pe_valid,
    output logic                   pe_ready,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic                   req_we,
    output logic [AW-1:0]          req_addr,
    output logic [DW-1:0]          req_wdata,
    input  logic                   rsp_valid,
    input  logic [DW-1:0]          rsp_data,
    output logic [DW-1:0]          pe_out,
    output logic                   pe_out_valid,
    output logic                   busy,
    output logic                   done
`ifdef LSU_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int SELW = $clog2(NPE);
    localparam int PTRW = $clog2(DEPTH);
    localparam int OCCW = PTRW + 1;
    localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // latched command
    logic            mode_q;
    logic [SELW-1:0] sel_q;
    logic [AW-1:0]   stride_q;
    logic [15:0]     count_q;

    // progress counters
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     issued_q, issued_d;   // accepted requests
    logic [15:0]     pushes_q, pushes_d;   // words taken from the PE
    logic [15:0]     rcvd_q, rcvd_d;       // load responses taken
    logic [OCCW-1:0] outst_q, outst_d;

    // store FIFO
    logic [DW-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCCW-1:0] fcnt_q, fcnt_d;

    logic [DW-1:0]   pe_out_q;
    logic            pe_out_valid_q;

    logic            run;
    logic            is_store;
    logic            start_acc;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            accept;
    logic            pop;
    logic            ld_acc;
    logic            rsp_take;
    logic            store_last;
    logic            load_last;
    logic [DW-1:0]   sel_data;

    assign run        = (state_q == S_RUN);
    assign is_store   = mode_q;
    assign start_acc  = (state_q == S_IDLE) && start;
    assign fifo_full  = (fcnt_q == OCC_FULL);
    assign fifo_empty = (fcnt_q == '0);
    assign sel_data   = pe_data[int'(sel_q)*DW +: DW];

    assign pe_ready   = run && is_store && !fifo_full && (pushes_q < count_q);
    assign push       = pe_valid && pe_ready;

    // Load requests stay asserted until taken: issued and outstanding only
    // move on acceptance or on a response, neither of which can lower them.
    assign req_valid  = run && (is_store ? !fifo_empty
                                         : ((issued_q < count_q) && (outst_q < OCC_FULL)));
    assign req_we     = is_store;
    assign req_addr   = addr_q;
    assign req_wdata  = mem_q[rd_ptr_q];

    assign accept     = req_valid && req_ready;
    assign pop        = accept && is_store;
    assign ld_acc     = accept && !is_store;
    assign rsp_take   = run && !is_store && rsp_valid && (outst_q != '0);

    assign store_last = pop && ((issued_q + 16'd1) == count_q);
    assign load_last  = rsp_take && ((rcvd_q + 16'd1) == count_q);

    assign pe_out       = pe_out_q;
    assign pe_out_valid = pe_out_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        pushes_d = pushes_q;
        rcvd_d   = rcvd_q;
        outst_d  = outst_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = (cfg_count == 16'd0) ? S_DONE : S_RUN;
                    addr_d   = cfg_base;
                    issued_d = '0;
                    pushes_d = '0;
                    rcvd_d   = '0;
                    outst_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    fcnt_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + 16'd1;
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTRW'(1);
                    pushes_d = pushes_q + 16'd1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTRW'(1);
                end
                case ({push, pop})
                    2'b10:   fcnt_d = fcnt_q + OCCW'(1);
                    2'b01:   fcnt_d = fcnt_q - OCCW'(1);
                    default: fcnt_d = fcnt_q;
                endcase
                case ({ld_acc, rsp_take})
                    2'b10:   outst_d = outst_q + OCCW'(1);
                    2'b01:   outst_d = outst_q - OCCW'(1);
                    default: outst_d = outst_q;
                endcase
                if (rsp_take) begin
                    rcvd_d = rcvd_q + 16'd1;
                end
                if (store_last || load_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mode_q         <= 1'b0;
            sel_q          <= '0;
            stride_q       <= '0;
            count_q        <= '0;
            addr_q         <= '0;
            issued_q       <= '0;
            pushes_q       <= '0;
            rcvd_q         <= '0;
            outst_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fcnt_q         <= '0;
            pe_out_q       <= '0;
            pe_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issued_q       <= issued_d;
            pushes_q       <= pushes_d;
            rcvd_q         <= rcvd_d;
            outst_q        <= outst_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fcnt_q         <= fcnt_d;
            pe_out_valid_q <= rsp_take;
            if (rsp_take) begin
                pe_out_q <= rsp_data;
            end
            if (start_acc) begin
                mode_q   <= cfg_mode;
                sel_q    <= cfg_pe_sel;
                stride_q <= cfg_stride;
                count_q  <= cfg_count;
            end
        end
    end

    // FIFO storage carries data only; occupancy above decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_data;
        end
    end

`ifdef LSU_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (req_valid && !req_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
